// File: rtl/mul_ctrl_if.sv
// Request/response handshake bundle between ALU issue logic and the multiply controller.
// Latency: none, pure wiring.
// Backpressure: valid/ready on both the request and the response channel.
interface mul_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;

    // Issue side: presents requests, consumes results.
    modport master (
        output req_valid, req_op, req_rs1, req_rs2, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    // Controller side: accepts requests, produces results.
    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/mul_ctrl.sv
// Sequencer for the multi-cycle radix-4 multiplier: extends operands, drives load/start/cycle index, returns a result half.
// Latency: accept at edge T, resp_valid from T+19 (T+1 for zero operands when MUL_CTRL_ZERO_BYPASS_EN is defined).
// Backpressure: req_ready only in IDLE; result held stable in DONE until resp_ready; kill aborts any in-flight op.
module mul_ctrl #(
    parameter int XLEN      = 32,
    parameter int MULOP_LEN = XLEN + 1,
    parameter int CYC_W     = 5,
    parameter int NSTEP     = (MULOP_LEN + 1) / 2
) (
    input  logic                   clk,
    input  logic                   rst,
    mul_ctrl_if.slave              bus,
    input  logic                   kill,
    output logic                   busy,
    output logic [MULOP_LEN-1:0]   mul_op1,
    output logic [MULOP_LEN-1:0]   mul_op2,
    output logic                   mul_sel_en,
    output logic                   mul_start_en,
    output logic [CYC_W-1:0]       mul_pc_cycle,
    input  logic [2*MULOP_LEN-1:0] mul_res
);
    typedef enum logic [1:0] {IDLE, START, CALC, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CYC_W-1:0] cnt;
    logic [CYC_W-1:0] cnt_nxt;
    logic [1:0]      op_q;
    logic            accept;
    logic            op1_msb;
    logic            op2_msb;
    logic [XLEN-1:0] res_half;
    logic            unused_res_top;

    // rs1 is signed for everything but MULHU; rs2 is signed only for MUL/MULH.
    assign op1_msb = (bus.req_op != 2'b11) & bus.req_rs1[XLEN-1];
    assign op2_msb = ~bus.req_op[1] & bus.req_rs2[XLEN-1];
    assign accept  = (state == IDLE) && bus.req_valid && !kill;
    assign busy    = (state != IDLE);

    // The two extension bits above the 64-bit product never reach the result.
    assign unused_res_top = ^mul_res[2*MULOP_LEN-1:2*XLEN];

`ifdef MUL_CTRL_ZERO_BYPASS_EN
    logic req_zero;
    logic zero_q;
    assign req_zero = (bus.req_rs1 == '0) || (bus.req_rs2 == '0);

    // Remember whether the accepted op short-circuits to a zero result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (accept) begin
            zero_q <= req_zero;
        end
    end
`endif

    // State, step counter and operand capture; operands only change on accept so they hold through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= 2'b00;
            mul_op1 <= '0;
            mul_op2 <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                op_q    <= bus.req_op;
                mul_op1 <= {op1_msb, bus.req_rs1};
                mul_op2 <= {op2_msb, bus.req_rs2};
            end
        end
    end

    // Next-state and multiplier/handshake controls.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        mul_sel_en     = 1'b0;
        mul_start_en   = 1'b0;
        mul_pc_cycle   = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                cnt_nxt       = '0;
                if (accept) begin
`ifdef MUL_CTRL_ZERO_BYPASS_EN
                    state_nxt = req_zero ? DONE : START;
`else
                    state_nxt = START;
`endif
                end
            end
            START: begin
                mul_sel_en   = 1'b1;
                mul_start_en = 1'b1;
                mul_pc_cycle = CYC_W'(1);
                cnt_nxt      = CYC_W'(2);
                state_nxt    = CALC;
            end
            CALC: begin
                // Index runs 2..NSTEP+1, one accumulate step per cycle.
                mul_sel_en   = 1'b1;
                mul_pc_cycle = cnt;
                cnt_nxt      = cnt + CYC_W'(1);
                if (cnt == CYC_W'(NSTEP + 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (kill && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    // MUL returns the low word, all MULH variants the high word; forced to zero outside DONE.
    always_comb begin
        res_half = (op_q == 2'b00) ? mul_res[XLEN-1:0] : mul_res[2*XLEN-1:XLEN];
        bus.resp_data = '0;
        if (bus.resp_valid) begin
`ifdef MUL_CTRL_ZERO_BYPASS_EN
            bus.resp_data = zero_q ? '0 : res_half;
`else
            bus.resp_data = res_half;
`endif
        end
    end
endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl with a behavioural multiplier that only yields the product after exactly 17 steps.
// Latency: checks first resp_valid at 19 cycles after accept (1 for zero-bypass builds).
// Backpressure: exercises resp_ready stalls, kill in IDLE/CALC and reset mid-operation.
`timescale 1ns/1ps
module tb_mul_ctrl;
    localparam int XLEN      = 32;
    localparam int MULOP_LEN = 33;
    localparam int CYC_W     = 5;
    localparam logic [65:0] GARBAGE = 66'h2_A5A5_A5A5_0000_0000;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   kill = 1'b0;
    logic                   busy;
    logic [MULOP_LEN-1:0]   mul_op1;
    logic [MULOP_LEN-1:0]   mul_op2;
    logic                   mul_sel_en;
    logic                   mul_start_en;
    logic [CYC_W-1:0]       mul_pc_cycle;
    logic [2*MULOP_LEN-1:0] mul_res;

    mul_ctrl_if #(.XLEN(XLEN)) bus ();

    mul_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .kill         (kill),
        .busy         (busy),
        .mul_op1      (mul_op1),
        .mul_op2      (mul_op2),
        .mul_sel_en   (mul_sel_en),
        .mul_start_en (mul_start_en),
        .mul_pc_cycle (mul_pc_cycle),
        .mul_res      (mul_res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          lat;
        int          starts;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   acc_last  = -100;
    int   n_start   = 0;
    int   first_cyc = 0;
    logic prev_vld  = 1'b0;
    exp_t e_mon;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: product only after the 17th accumulate step, garbage otherwise.
    logic [65:0]        acc_r = '0;
    int                 steps = 0;
    logic signed [65:0] p1;
    logic signed [65:0] p2;
    logic signed [65:0] prod;
    assign p1      = {{33{mul_op1[32]}}, mul_op1};
    assign p2      = {{33{mul_op2[32]}}, mul_op2};
    assign prod    = p1 * p2;
    assign mul_res = acc_r;

    always @(posedge clk) begin
        if (mul_sel_en && mul_start_en) begin
            acc_r <= '0;
            steps <= 0;
        end else if (mul_sel_en) begin
            steps <= steps + 1;
            acc_r <= (steps == 16) ? prod : (GARBAGE | 66'(steps));
        end
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: control-sequence checks every cycle, scoreboard pop on each response handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (mul_start_en) begin
                check("start_time", 66'(cyc), 66'(acc_last));
                check("start_pc", 66'(mul_pc_cycle), 66'd1);
                n_start++;
            end else if (mul_sel_en) begin
                check("calc_pc", 66'(mul_pc_cycle), 66'(steps + 2));
            end
            if (!bus.resp_valid) check("idle_data_zero", 66'(bus.resp_data), 66'd0);
            if (bus.resp_valid && !prev_vld) first_cyc = cyc;
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got data %0h with nothing outstanding (cycle %0d)", bus.resp_data, cyc);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("resp_data", 66'(bus.resp_data), 66'(e_mon.data));
                    check("resp_latency", 66'(first_cyc - e_mon.acc + 1), 66'(e_mon.lat));
                    check("start_pulses", 66'(n_start), 66'(e_mon.starts));
                end
            end
            prev_vld = bus.resp_valid;
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit want);
        int   t;
        exp_t e;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready got 0 expected 1 (cycle %0d)", cyc);
        end else begin
            acc_last = cyc + 1;
            n_start  = 0;
            if (want) begin
                e.data   = exp;
                e.acc    = cyc + 1;
                e.lat    = 19;
                e.starts = 1;
`ifdef MUL_CTRL_ZERO_BYPASS_EN
                if (a == 0 || b == 0) begin
                    e.lat    = 1;
                    e.starts = 0;
                end
`endif
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 66'(exp_q.size()), 66'd0);
    endtask

    task automatic wait_pc(input logic [4:0] idx);
        int t;
        t = 0;
        while (!(mul_sel_en && !mul_start_en && mul_pc_cycle == idx) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("reach_calc_idx", 66'(mul_pc_cycle), 66'(idx));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 66'(bus.req_ready), 66'd1);
        check({tag, "_resp_valid"}, 66'(bus.resp_valid), 66'd0);
        check({tag, "_resp_data"}, 66'(bus.resp_data), 66'd0);
        check({tag, "_busy"}, 66'(busy), 66'd0);
        check({tag, "_sel_en"}, 66'(mul_sel_en), 66'd0);
        check({tag, "_start_en"}, 66'(mul_start_en), 66'd0);
        check({tag, "_pc_cycle"}, 66'(mul_pc_cycle), 66'd0);
        check({tag, "_op1"}, 66'(mul_op1), 66'd0);
        check({tag, "_op2"}, 66'(mul_op2), 66'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.resp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back ops with the consumer always ready.
        do_op(2'b00, 32'd3,        32'd5,        32'h0000000F, 1'b1);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        do_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
        do_op(2'b10, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b1);
        do_op(2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1);
        do_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1);
        do_op(2'b00, 32'h00000000, 32'h00001234, 32'h00000000, 1'b1);
        drain();

        // Consumer stalls for 5 cycles in DONE.
        bus.resp_ready = 1'b0;
        do_op(2'b00, 32'h12345678, 32'h10, 32'h23456780, 1'b1);
        bad = 0;
        while (!bus.resp_valid && bad < 50) begin
            @(negedge clk);
            bad++;
        end
        check("bp_reach_done", 66'(bus.resp_valid), 66'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid_held", 66'(bus.resp_valid), 66'd1);
            check("bp_data_held", 66'(bus.resp_data), 66'h23456780);
            check("bp_req_ready", 66'(bus.req_ready), 66'd0);
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_req_ready", 66'(bus.req_ready), 66'd1);
        check("bp_idle_resp_valid", 66'(bus.resp_valid), 66'd0);
        do_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1);
        drain();

        // kill together with a request in IDLE: nothing accepted.
        @(posedge clk);
        #1;
        kill          = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_rs1   = 32'd3;
        bus.req_rs2   = 32'd3;
        @(posedge clk);
        #1;
        kill          = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("idle_kill_busy", 66'(busy), 66'd0);

        // kill at CALC index 9: no response ever, then a clean op.
        do_op(2'b00, 32'd5, 32'd5, 32'd0, 1'b0);
        wait_pc(5'd9);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill_busy", 66'(busy), 66'd0);
        check("kill_resp_valid", 66'(bus.resp_valid), 66'd0);
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.resp_valid) bad = 1;
        end
        check("kill_no_resp", 66'(bad), 66'd0);
        do_op(2'b00, 32'd7, 32'd6, 32'd42, 1'b1);
        drain();

        // Reset mid-CALC, then a fresh op.
        do_op(2'b11, 32'd3, 32'd3, 32'd0, 1'b0);
        wait_pc(5'd10);
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        do_op(2'b11, 32'h00010000, 32'h00010000, 32'h00000001, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Sequencing controller for the multi-cycle radix-4 multiplier datapath.
- Accepts RV32M multiply requests (MUL/MULH/MULHSU/MULHU) from the ALU issue stage via a valid/ready handshake.
- Builds the 33-bit extended operands, drives the multiplier's load/start/cycle-index controls, selects the result half, and returns it via a valid/ready response.
- Sits between the ALU dispatch logic and the multiplier instance; owns all multiplier control.

Parameters:
- XLEN, 32, architectural operand width.
- MULOP_LEN, 33, multiplier operand width (XLEN+1, one extension bit).
- CYC_W, 5, width of the cycle index driven to the multiplier.
- NSTEP, 17, radix-4 accumulate steps, equal to (MULOP_LEN+1)/2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  multiply request valid
- req_ready  out  1  controller can accept a request
- req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- req_rs1  in  XLEN  multiplicand
- req_rs2  in  XLEN  multiplier
- kill  in  1  pipeline flush; abort current operation
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_data  out  XLEN  selected result
- busy  out  1  operation in flight (state != IDLE)
- mul_op1  out  MULOP_LEN  extended rs1 to multiplier, registered
- mul_op2  out  MULOP_LEN  extended rs2 to multiplier, registered
- mul_sel_en  out  1  multiplier register load enable
- mul_start_en  out  1  multiplier init (loads op2, clears accumulator)
- mul_pc_cycle  out  CYC_W  cycle index; multiplier shifts by 2*(index-2)
- mul_res  in  2*MULOP_LEN  accumulated product from multiplier

Behaviour:
- Reset: state=IDLE; cnt, op regs, mul_op1 and mul_op2 all 0. Outputs: req_ready=1, resp_valid=0, resp_data=0, busy=0, mul_sel_en=0, mul_start_en=0, mul_pc_cycle=0.
- Operand extension, captured on accept:
  - mul_op1 = sign-extended rs1 for MUL/MULH/MULHSU; zero-extended rs1 for MULHU.
  - mul_op2 = sign-extended rs2 for MUL/MULH; zero-extended rs2 for MULHSU/MULHU.
- FSM states IDLE, START, CALC, DONE:
  - IDLE: req_ready=1. On req_valid&&!kill, latch op and operands, then go to START.
  - START (1 cycle): mul_sel_en=1, mul_start_en=1, mul_pc_cycle=1. Next state CALC, cnt=2.
  - CALC: mul_sel_en=1, mul_start_en=0, mul_pc_cycle=cnt, cnt+=1. When cnt==NSTEP+1 (18), go to DONE. This gives exactly NSTEP accumulate cycles.
  - DONE: resp_valid=1, mul_sel_en=0 so the accumulator holds. resp_data = mul_res[XLEN-1:0] for MUL, else mul_res[2*XLEN-1:XLEN]. On resp_ready, go to IDLE.
- Latency: request accepted at edge T → START T+1, CALC T+2..T+18, resp_valid from T+19. Back-to-back throughput is 1 op per 20 cycles when resp_ready=1.
- req_ready=0 in all states except IDLE. No new request is accepted in the DONE cycle; a handshake there occurs the cycle after.
- resp_data is 0 whenever resp_valid=0.
- Backpressure: resp_valid and resp_data stay stable while resp_ready=0.
- kill:
  - In START, CALC or DONE: next state IDLE, resp_valid=0 next cycle, result discarded.
  - In IDLE: the simultaneous request is not accepted.
- rst asserted mid-operation: immediate return to reset values; the multiplier's partial state is ignored because the next op re-issues start.
- mul_op1/mul_op2 stay stable from START through DONE.

Optional Feature:
- Macro MUL_CTRL_ZERO_BYPASS_EN.
- Defined: on accept, if req_rs1==0 or req_rs2==0, skip START/CALC and go directly to DONE with resp_data forced to 0. resp_valid appears at T+1, and the multiplier is not enabled (mul_sel_en=0).
- Undefined: zero operands take the full 19-cycle path and produce 0 via the datapath.

Test Plan:
- MUL rs1=3, rs2=5, resp_ready=1 → resp_valid first at T+19, resp_data=0x0000000F; mul_start_en high exactly at T+1; mul_pc_cycle steps 2..18.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHU same operands → 0xFFFFFFFE.
- MULHSU rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF. MUL 0x80000000×0x80000000 → 0x00000000, MULH of the same → 0x40000000.
- resp_ready held 0 for 5 cycles in DONE → resp_valid and resp_data stable, req_ready=0; then resp_ready=1 → IDLE next cycle, new request accepted.
- kill asserted at CALC cnt=9 → resp_valid never asserts, busy=0 next cycle; a following MUL 7×6 returns 42.
- rst asserted mid-CALC then released → all outputs at reset values; a following MULHU 0x10000×0x10000 returns 0x00000001. With the macro defined, MUL 0×1234 returns resp_valid at T+1 with data 0.
